// File: rtl/spi_master.sv
`timescale 1ns/1ps
// spi_master: SPI bus master, all four CPOL/CPHA modes, MSB first.
// Frame: SETUP (CLK_DIV cycles) -> 2*DATA_WIDTH sclk edges -> HOLD (CLK_DIV cycles).
// Optional build macro SPI_MASTER_LOOPBACK_EN adds a loopback input that
// routes dout back into the receive shifter.
//
//  state   | meaning
//  --------+---------------------------------------------------------------
//  S_IDLE  | csb high, sclk tracks CPOL input, waiting for start
//  S_SETUP | csb low, sclk idle, CLK_DIV cycles before the first edge
//  S_XFER  | sclk toggles every CLK_DIV cycles, shift out / sample in
//  S_HOLD  | sclk idle, CLK_DIV cycles before csb rises and done pulses
module spi_master #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 4
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic                  CPOL,
    input  logic                  CPHA,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] datai,
    output logic [DATA_WIDTH-1:0] datao,
    output logic                  busy,
    output logic                  done,
    output logic                  csb,
    output logic                  sclk,
    output logic                  dout,
`ifdef SPI_MASTER_LOOPBACK_EN
    input  logic                  loopback,
`endif
    input  logic                  din
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int EW = $clog2(2 * DATA_WIDTH);
    localparam logic [CW-1:0] CNT_LOAD  = CW'(CLK_DIV - 1);
    localparam logic [EW-1:0] EDGE_LAST = EW'(2 * DATA_WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_XFER, S_HOLD} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [EW-1:0]         edge_q, edge_d;
    logic                  cpol_q, cpol_d;
    logic                  cpha_q, cpha_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d;
    logic [DATA_WIDTH-1:0] rx_q, rx_d;
    logic [DATA_WIDTH-1:0] datao_q, datao_d;
    logic                  sclk_q, sclk_d;
    logic                  csb_q, csb_d;
    logic                  dout_q, dout_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  rx_bit;
    logic                  lb_start;

`ifdef SPI_MASTER_LOOPBACK_EN
    logic lb_q, lb_d;
    assign rx_bit   = lb_q ? dout_q : din;
    assign lb_start = loopback;
`else
    assign rx_bit   = din;
    assign lb_start = 1'b0;
`endif

    // State and datapath registers; synchronous reset discards any partial frame.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            edge_q  <= '0;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            tx_q    <= '0;
            rx_q    <= '0;
            datao_q <= '0;
            sclk_q  <= 1'b0;
            csb_q   <= 1'b1;
            dout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SPI_MASTER_LOOPBACK_EN
            lb_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            edge_q  <= edge_d;
            cpol_q  <= cpol_d;
            cpha_q  <= cpha_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            datao_q <= datao_d;
            sclk_q  <= sclk_d;
            csb_q   <= csb_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SPI_MASTER_LOOPBACK_EN
            lb_q    <= lb_d;
`endif
        end
    end

    // Next-state and output logic; timers are down-counters ending at zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        edge_d  = edge_q;
        cpol_d  = cpol_q;
        cpha_d  = cpha_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        datao_d = datao_q;
        sclk_d  = sclk_q;
        csb_d   = csb_q;
        dout_d  = dout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef SPI_MASTER_LOOPBACK_EN
        lb_d    = lb_q;
`endif
        case (state_q)
            S_IDLE: begin
                sclk_d = CPOL;
                // done_q blocks a start that arrives in the done cycle
                if (start && !done_q) begin
                    cpol_d  = CPOL;
                    cpha_d  = CPHA;
                    csb_d   = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = CNT_LOAD;
                    edge_d  = '0;
                    rx_d    = '0;
                    state_d = S_SETUP;
`ifdef SPI_MASTER_LOOPBACK_EN
                    lb_d    = lb_start;
`endif
                    if (!CPHA) begin
                        dout_d = datai[DATA_WIDTH-1];
                        tx_d   = datai << 1;
                    end else begin
                        tx_d   = datai;
                    end
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) begin
                    cnt_d   = CNT_LOAD;
                    state_d = S_XFER;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_XFER: begin
                if (cnt_q == '0) begin
                    cnt_d  = CNT_LOAD;
                    sclk_d = ~sclk_q;
                    edge_d = edge_q + EW'(1);
                    // even edge index is the leading edge; CPHA picks which edge samples
                    if (edge_q[0] == cpha_q) begin
                        rx_d = (rx_q << 1) | DATA_WIDTH'(rx_bit);
                    end else if (edge_q != EDGE_LAST) begin
                        dout_d = tx_q[DATA_WIDTH-1];
                        tx_d   = tx_q << 1;
                    end
                    if (edge_q == EDGE_LAST) begin
                        state_d = S_HOLD;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    csb_d   = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    datao_d = rx_q;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign datao = datao_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign csb   = csb_q;
    assign sclk  = sclk_q;
    assign dout  = dout_q;

endmodule

// File: tb/tb_spi_master.sv
`timescale 1ns/1ps
// tb_spi_master: directed bench for spi_master with a behavioural echo slave.
module tb_spi_master;

    localparam int CD  = 4;
    localparam int PER = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstb, cpol, cpha, start, din, csb, sclk, dout, busy, done;
    logic [7:0] datai, datao;
    logic       force_din0;
    logic       cpol2, cpha2, start2, csb2, sclk2, dout2, busy2, done2;
    logic [7:0] datai2, datao2;
`ifdef SPI_MASTER_LOOPBACK_EN
    logic       loopback;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    spi_master #(.DATA_WIDTH(8), .CLK_DIV(CD)) dut (
        .clk(clk), .rstb(rstb), .CPOL(cpol), .CPHA(cpha), .start(start),
        .datai(datai), .datao(datao), .busy(busy), .done(done), .csb(csb),
        .sclk(sclk), .dout(dout),
`ifdef SPI_MASTER_LOOPBACK_EN
        .loopback(loopback),
`endif
        .din(din)
    );

    // second instance at CLK_DIV=1 with MISO wired to its own MOSI
    spi_master #(.DATA_WIDTH(8), .CLK_DIV(1)) dut2 (
        .clk(clk), .rstb(rstb), .CPOL(cpol2), .CPHA(cpha2), .start(start2),
        .datai(datai2), .datao(datao2), .busy(busy2), .done(done2), .csb(csb2),
        .sclk(sclk2), .dout(dout2),
`ifdef SPI_MASTER_LOOPBACK_EN
        .loopback(1'b0),
`endif
        .din(dout2)
    );

    // behavioural slave: echoes 0x55, captures MOSI
    logic [7:0] s_tx, s_rx;
    int         s_cnt;
    logic       s_miso = 1'b0;
    logic       s_cpol = 1'b0, s_cpha = 1'b0;
    logic       s_lead;
    bit         mon_en = 1'b0;
    bit         samp_valid = 1'b0;
    time        t_dout = 0, t_samp = 0;
    int         stab_err = 0;

    assign din = force_din0 ? 1'b0 : s_miso;

    always @(negedge csb) begin
        s_tx  = 8'h55;
        s_rx  = 8'h00;
        s_cnt = 0;
        if (!s_cpha) begin
            s_miso = s_tx[7];
            s_tx   = s_tx << 1;
        end
    end

    always @(sclk) begin
        if (csb === 1'b0) begin
            s_lead = (sclk !== s_cpol);
            if (s_lead ^ s_cpha) begin
                s_rx  = {s_rx[6:0], dout};
                s_cnt = s_cnt + 1;
                if (mon_en && ($time - t_dout) < (CD - 1) * PER) stab_err++;
                t_samp     = $time;
                samp_valid = 1'b1;
            end else begin
                s_miso = s_tx[7];
                s_tx   = s_tx << 1;
            end
        end
    end

    always @(dout) begin
        if (mon_en && samp_valid && ($time - t_samp) < (CD - 1) * PER) stab_err++;
        t_dout = $time;
    end

    task automatic do_frame(input logic p_cpol, input logic p_cpha, input logic [7:0] d,
                            output logic [7:0] rx_o, output int low_o, output bit to_o);
        @(negedge clk);
        cpol = p_cpol; cpha = p_cpha; s_cpol = p_cpol; s_cpha = p_cpha;
        @(negedge clk);
        datai = d; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        low_o = 0;
        to_o  = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if (done === 1'b1) begin
                to_o = 1'b0;
                break;
            end
            if (csb === 1'b0) low_o++;
            @(negedge clk);
        end
        rx_o = datao;
    endtask

    task automatic test_reset();
        rstb = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++; if (csb !== 1'b1)  begin n_fail++; $display("FAIL reset_csb: got %b expected 1", csb); end
        n_tests++; if (sclk !== 1'b0) begin n_fail++; $display("FAIL reset_sclk: got %b expected 0", sclk); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_tests++; if (datao !== 8'h00) begin n_fail++; $display("FAIL reset_datao: got %h expected 00", datao); end
        n_tests++; if (dout !== 1'b0) begin n_fail++; $display("FAIL reset_dout: got %b expected 0", dout); end
        rstb = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_modes();
        logic [7:0] pats [4];
        logic [7:0] rx;
        int         low;
        bit         to;
        pats = '{8'h00, 8'h5A, 8'hC3, 8'hFF};
        for (int m = 0; m < 4; m++) begin
            for (int p = 0; p < 4; p++) begin
                do_frame(m[1], m[0], pats[p], rx, low, to);
                n_tests++; if (to) begin n_fail++; $display("FAIL mode%0d_timeout: got no done expected done", m); end
                n_tests++; if (rx !== 8'h55) begin n_fail++; $display("FAIL mode%0d_datao: got %h expected 55", m, rx); end
                n_tests++; if (s_rx !== pats[p]) begin n_fail++; $display("FAIL mode%0d_slave_rx: got %h expected %h", m, s_rx, pats[p]); end
                n_tests++; if (low != 72) begin n_fail++; $display("FAIL mode%0d_csb_low: got %0d expected 72", m, low); end
                n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mode%0d_busy_at_done: got %b expected 0", m, busy); end
            end
        end
    endtask

    task automatic test_edge_timing();
        logic [7:0] rx;
        int         low;
        bit         to;
        for (int k = 0; k < 2; k++) begin
            stab_err   = 0;
            samp_valid = 1'b0;
            mon_en     = 1'b1;
            do_frame(k[0], k[0], 8'hA6, rx, low, to);
            mon_en = 1'b0;
            n_tests++; if (stab_err != 0) begin n_fail++; $display("FAIL edge%0d_dout_stable: got %0d violations expected 0", k * 3, stab_err); end
            n_tests++; if (s_cnt != 8) begin n_fail++; $display("FAIL edge%0d_sample_count: got %0d expected 8", k * 3, s_cnt); end
            n_tests++; if (rx !== 8'h55) begin n_fail++; $display("FAIL edge%0d_datao: got %h expected 55", k * 3, rx); end
            n_tests++; if (s_rx !== 8'hA6) begin n_fail++; $display("FAIL edge%0d_slave_rx: got %h expected a6", k * 3, s_rx); end
        end
    endtask

    task automatic test_back_to_back();
        bit seen;
        @(negedge clk);
        cpol = 1'b0; cpha = 1'b0; s_cpol = 1'b0; s_cpha = 1'b0;
        @(negedge clk);
        datai = 8'h5A; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        datai = 8'h11; cpol = 1'b1; cpha = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; cpol = 1'b0; cpha = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (done === 1'b1) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        n_tests++; if (!seen) begin n_fail++; $display("FAIL b2b_first_done: got no done expected done"); end
        datai = 8'hC3; start = 1'b1;
        @(negedge clk);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_start_in_done_cycle: got busy %b expected 0", busy); end
        n_tests++; if (csb !== 1'b1) begin n_fail++; $display("FAIL b2b_csb_gap: got %b expected 1", csb); end
        n_tests++; if (s_rx !== 8'h5A) begin n_fail++; $display("FAIL b2b_first_slave_rx: got %h expected 5a", s_rx); end
        n_tests++; if (datao !== 8'h55) begin n_fail++; $display("FAIL b2b_first_datao: got %h expected 55", datao); end
        @(negedge clk);
        start = 1'b0;
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_second_busy: got %b expected 1", busy); end
        n_tests++; if (csb !== 1'b0) begin n_fail++; $display("FAIL b2b_second_csb: got %b expected 0", csb); end
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (done === 1'b1) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        n_tests++; if (!seen) begin n_fail++; $display("FAIL b2b_second_done: got no done expected done"); end
        n_tests++; if (s_rx !== 8'hC3) begin n_fail++; $display("FAIL b2b_second_slave_rx: got %h expected c3", s_rx); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] rx;
        int         low, dones;
        bit         to, reached;
        @(negedge clk);
        cpol = 1'b0; cpha = 1'b0; s_cpol = 1'b0; s_cpha = 1'b0;
        @(negedge clk);
        datai = 8'hA5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (s_cnt >= 3) begin reached = 1'b1; break; end
            @(negedge clk);
        end
        n_tests++; if (!reached) begin n_fail++; $display("FAIL rstmid_3bits: got %0d samples expected 3", s_cnt); end
        rstb = 1'b0;
        @(negedge clk);
        n_tests++; if (csb !== 1'b1)  begin n_fail++; $display("FAIL rstmid_csb: got %b expected 1", csb); end
        n_tests++; if (sclk !== 1'b0) begin n_fail++; $display("FAIL rstmid_sclk: got %b expected 0", sclk); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done: got %b expected 0", done); end
        rstb = 1'b1;
        dones = 0;
        repeat (100) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        n_tests++; if (dones != 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d expected 0", dones); end
        do_frame(1'b0, 1'b0, 8'h3C, rx, low, to);
        n_tests++; if (to) begin n_fail++; $display("FAIL rstmid_next_timeout: got no done expected done"); end
        n_tests++; if (s_rx !== 8'h3C) begin n_fail++; $display("FAIL rstmid_next_slave_rx: got %h expected 3c", s_rx); end
        n_tests++; if (rx !== 8'h55) begin n_fail++; $display("FAIL rstmid_next_datao: got %h expected 55", rx); end
        n_tests++; if (low != 72) begin n_fail++; $display("FAIL rstmid_next_csb_low: got %0d expected 72", low); end
    endtask

    task automatic test_clkdiv1();
        logic [7:0] pats [2];
        int         low;
        bit         seen;
        pats = '{8'h96, 8'h3C};
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            cpol2 = k[0]; cpha2 = k[0];
            @(negedge clk);
            datai2 = pats[k]; start2 = 1'b1;
            @(negedge clk);
            start2 = 1'b0;
            low = 0; seen = 1'b0;
            for (int i = 0; i < 200; i++) begin
                if (done2 === 1'b1) begin seen = 1'b1; break; end
                if (csb2 === 1'b0) low++;
                @(negedge clk);
            end
            n_tests++; if (!seen) begin n_fail++; $display("FAIL div1_mode%0d_timeout: got no done expected done", k * 3); end
            n_tests++; if (datao2 !== pats[k]) begin n_fail++; $display("FAIL div1_mode%0d_datao: got %h expected %h", k * 3, datao2, pats[k]); end
            n_tests++; if (low != 18) begin n_fail++; $display("FAIL div1_mode%0d_csb_low: got %0d expected 18", k * 3, low); end
        end
    endtask

`ifdef SPI_MASTER_LOOPBACK_EN
    task automatic test_loopback();
        logic [7:0] rx;
        int         low;
        bit         to;
        loopback = 1'b1; force_din0 = 1'b1;
        for (int k = 0; k < 2; k++) begin
            do_frame(k[0], k[0], 8'h96, rx, low, to);
            n_tests++; if (to) begin n_fail++; $display("FAIL loopback%0d_timeout: got no done expected done", k * 3); end
            n_tests++; if (rx !== 8'h96) begin n_fail++; $display("FAIL loopback%0d_datao: got %h expected 96", k * 3, rx); end
            n_tests++; if (low != 72) begin n_fail++; $display("FAIL loopback%0d_csb_low: got %0d expected 72", k * 3, low); end
        end
        loopback = 1'b0; force_din0 = 1'b0;
    endtask
`endif

    initial begin
        rstb = 1'b0; cpol = 1'b0; cpha = 1'b0; start = 1'b0; datai = 8'h00;
        cpol2 = 1'b0; cpha2 = 1'b0; start2 = 1'b0; datai2 = 8'h00;
        force_din0 = 1'b0;
`ifdef SPI_MASTER_LOOPBACK_EN
        loopback = 1'b0;
`endif
        test_reset();
        test_modes();
        test_edge_timing();
        test_back_to_back();
        test_reset_midframe();
        test_clkdiv1();
`ifdef SPI_MASTER_LOOPBACK_EN
        test_loopback();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
